// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display that shares one HEX decoder across all digits. A prescaler produces
// a refresh tick every DIV clocks; each tick advances the digit index. New
// display data is captured into a shadow register on `load` and is moved into
// the active register only at a frame wrap, so a frame is never torn.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous active-high reset
//   load         in   1   one-cycle strobe capturing data_in/dots_in
//   data_in      in  16   four hex nibbles, digit 0 = bits[3:0]
//   dots_in      in   4   decimal point per digit, bit k = digit k
//   lz_blank_en  in   1   leading-zero blanking enable (live)
//   hex_out      out  4   nibble of the current digit
//   dot_out      out  1   decimal point of the current digit
//   blank        out  1   current digit slot is blanked
//   an_n         out  4   active-low one-hot digit select, 4'b1111 if blanked
//   frame_done   out  1   one-cycle pulse when the index wraps to digit 0
//   pending      out  1   shadow data waiting for the next frame boundary
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dots_in,
    input  logic        lz_blank_en,
    output logic [3:0]  hex_out,
    output logic        dot_out,
    output logic        blank,
    output logic [3:0]  an_n,
    output logic        frame_done,
    output logic        pending
);

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    // Mask of "this nibble and every more-significant nibble is zero".
    function automatic logic [3:0] upper_zero_mask(input logic [15:0] d);
        logic [3:0] m;
        m[3] = (d[15:12] == 4'h0);
        m[2] = m[3] & (d[11:8] == 4'h0);
        m[1] = m[2] & (d[7:4] == 4'h0);
        m[0] = m[1] & (d[3:0] == 4'h0);
        return m;
    endfunction

    logic [15:0] cnt_q,     cnt_d;
    logic [1:0]  idx_q,     idx_d;
    logic [15:0] active_q,  active_d;
    logic [3:0]  adots_q,   adots_d;
    logic [15:0] shadow_q,  shadow_d;
    logic [3:0]  sdots_q,   sdots_d;
    logic        pending_q, pending_d;
    logic        fdone_q,   fdone_d;

    logic        tick_s;
    logic        wrap_s;
    logic [3:0]  uz_mask_s;

    assign tick_s = (cnt_q == DIV_M1);
    assign wrap_s = tick_s & (idx_q == 2'd3);

    // Next-state logic for prescaler, digit index and the shadow/active pair.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        active_d  = active_q;
        adots_d   = adots_q;
        shadow_d  = shadow_q;
        sdots_d   = sdots_q;
        pending_d = pending_q;
        fdone_d   = wrap_s;

        if (tick_s) begin
            cnt_d = 16'd0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (load) begin
            shadow_d = data_in;
            sdots_d  = dots_in;
        end else begin
            shadow_d = shadow_q;
            sdots_d  = sdots_q;
        end

        // A load landing on the wrap tick bypasses the shadow so the new
        // frame already shows it; otherwise a waiting shadow is promoted.
        if (wrap_s && load) begin
            active_d  = data_in;
            adots_d   = dots_in;
            pending_d = 1'b0;
        end else if (wrap_s && pending_q) begin
            active_d  = shadow_q;
            adots_d   = sdots_q;
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 16'd0;
            idx_q     <= 2'd0;
            active_q  <= 16'd0;
            adots_q   <= 4'd0;
            shadow_q  <= 16'd0;
            sdots_q   <= 4'd0;
            pending_q <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            adots_q   <= adots_d;
            shadow_q  <= shadow_d;
            sdots_q   <= sdots_d;
            pending_q <= pending_d;
            fdone_q   <= fdone_d;
        end
    end

    assign uz_mask_s = upper_zero_mask(active_q);

    // Digit mux and blanking decode straight from the registers.
    always_comb begin
        hex_out = 4'h0;
        dot_out = 1'b0;
        blank   = 1'b0;
        an_n    = 4'b1111;

        case (idx_q)
            2'd0:    hex_out = active_q[3:0];
            2'd1:    hex_out = active_q[7:4];
            2'd2:    hex_out = active_q[11:8];
            2'd3:    hex_out = active_q[15:12];
            default: hex_out = 4'h0;
        endcase
        dot_out = adots_q[idx_q];

        // Digit 0 is never blanked so a zero value still shows "0".
        if (lz_blank_en && (idx_q != 2'd0) && uz_mask_s[idx_q] && !adots_q[idx_q]) begin
            blank = 1'b1;
        end else begin
            blank = 1'b0;
        end

        if (blank) begin
            an_n = 4'b1111;
        end else begin
            an_n = ~(4'b0001 << idx_q);
        end
    end

    assign frame_done = fdone_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dots_in;
    logic        lz_blank_en;
    logic [3:0]  hex_out;
    logic        dot_out;
    logic        blank;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        pending;

    int n_tests = 0;
    int n_fail  = 0;

    seven_seg_scan_ctrl #(.DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dots_in(dots_in),
        .lz_blank_en(lz_blank_en), .hex_out(hex_out), .dot_out(dot_out),
        .blank(blank), .an_n(an_n), .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] data;
        logic [3:0]  dots;
        logic        lz;
        int          adv;
        logic [3:0]  hex;
        logic        dot;
        logic        blank;
        logic [3:0]  an;
        logic        pend;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic [15:0] d,
                       input logic [3:0] dt, input logic lz, input int adv,
                       input logic [3:0] h, input logic dto, input logic b,
                       input logic [3:0] a, input logic p, input logic f);
        vec_t v;
        v.rst = r; v.ld = l; v.data = d; v.dots = dt; v.lz = lz; v.adv = adv;
        v.hex = h; v.dot = dto; v.blank = b; v.an = a; v.pend = p; v.fd = f;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {hex,dot,blank,an_n,pend,fd}=%h/%b/%b/%b/%b/%b expected %h/%b/%b/%b/%b/%b",
                     name, act[11:8], act[7], act[6], act[5:2], act[1], act[0],
                     exp[11:8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [11:0] outs();
        return {hex_out, dot_out, blank, an_n, pending, frame_done};
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        int twos;
        int fds;

        rst = 1'b1; load = 1'b0; data_in = 16'h0; dots_in = 4'h0; lz_blank_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", outs(), {4'h0, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0});
        rst = 1'b0;

        // Idle scan after reset (n = edges since reset release)
        add(0,0,16'h0,4'h0,0, 1, 4'h0,0,0,4'b1110,0,0); // n1
        add(0,0,16'h0,4'h0,0, 3, 4'h0,0,0,4'b1101,0,0); // n4 first tick DIV later
        add(0,0,16'h0,4'h0,0, 4, 4'h0,0,0,4'b1011,0,0); // n8
        add(0,0,16'h0,4'h0,0, 4, 4'h0,0,0,4'b0111,0,0); // n12
        add(0,0,16'h0,4'h0,0, 4, 4'h0,0,0,4'b1110,0,1); // n16 frame_done
        add(0,0,16'h0,4'h0,0, 1, 4'h0,0,0,4'b1110,0,0); // n17 pulse gone
        // Mid-frame load 1234 / dots 0010
        add(0,1,16'h1234,4'b0010,0, 1,  4'h0,0,0,4'b1110,1,0); // n18
        add(0,0,16'h0,4'h0,0,      13, 4'h0,0,0,4'b0111,1,0); // n31
        add(0,0,16'h0,4'h0,0, 1, 4'h4,0,0,4'b1110,0,1); // n32
        add(0,0,16'h0,4'h0,0, 4, 4'h3,1,0,4'b1101,0,0); // n36
        add(0,0,16'h0,4'h0,0, 4, 4'h2,0,0,4'b1011,0,0); // n40
        add(0,0,16'h0,4'h0,0, 4, 4'h1,0,0,4'b0111,0,0); // n44
        // Leading-zero blanking with 0005
        add(0,1,16'h0005,4'b0000,1, 1, 4'h1,0,0,4'b0111,1,0); // n45
        add(0,0,16'h0,4'h0,1, 3, 4'h5,0,0,4'b1110,0,1); // n48
        add(0,0,16'h0,4'h0,1, 4, 4'h0,0,1,4'b1111,0,0); // n52
        add(0,0,16'h0,4'h0,1, 4, 4'h0,0,1,4'b1111,0,0); // n56
        add(0,0,16'h0,4'h0,1, 4, 4'h0,0,1,4'b1111,0,0); // n60
        // Same value with dot on digit 2
        add(0,1,16'h0005,4'b0100,1, 1, 4'h0,0,1,4'b1111,1,0); // n61
        add(0,0,16'h0,4'h0,1, 3, 4'h5,0,0,4'b1110,0,1); // n64
        add(0,0,16'h0,4'h0,1, 4, 4'h0,0,1,4'b1111,0,0); // n68
        add(0,0,16'h0,4'h0,1, 4, 4'h0,1,0,4'b1011,0,0); // n72
        add(0,0,16'h0,4'h0,1, 4, 4'h0,0,1,4'b1111,0,0); // n76
        add(0,0,16'h0,4'h0,0, 1, 4'h0,0,0,4'b0111,0,0); // n77 lz sampled live
        // Load on the wrap-tick cycle
        add(0,0,16'h0,4'h0,0, 2, 4'h0,0,0,4'b0111,0,0); // n79 wrap tick state
        add(0,1,16'hABCD,4'h0,0, 1, 4'hD,0,0,4'b1110,0,1); // n80
        add(0,0,16'h0,4'h0,0, 4, 4'hC,0,0,4'b1101,0,0); // n84
        // Two loads in one frame: last wins
        add(0,1,16'h1111,4'h0,0, 1, 4'hC,0,0,4'b1101,1,0); // n85
        add(0,1,16'h2222,4'h0,0, 1, 4'hC,0,0,4'b1101,1,0); // n86
        add(0,0,16'h0,4'h0,0, 10, 4'h2,0,0,4'b1110,0,1); // n96
        add(0,0,16'h0,4'h0,0, 4,  4'h2,0,0,4'b1101,0,0); // n100
        add(0,0,16'h0,4'h0,0, 8,  4'h2,0,0,4'b0111,0,0); // n108
        // Load FFFF then reset at idx 2 before the wrap
        add(0,0,16'h0,4'h0,0, 4, 4'h2,0,0,4'b1110,0,1); // n112
        add(0,1,16'hFFFF,4'h0,0, 1, 4'h2,0,0,4'b1110,1,0); // n113
        add(0,0,16'h0,4'h0,0, 7, 4'h2,0,0,4'b1011,1,0); // n120
        add(1,0,16'h0,4'h0,0, 1, 4'h0,0,0,4'b1110,0,0); // reset -> n0
        add(0,0,16'h0,4'h0,0, 3, 4'h0,0,0,4'b1110,0,0); // n3 no tick yet
        add(0,0,16'h0,4'h0,0, 1, 4'h0,0,0,4'b1101,0,0); // n4 first tick
        add(0,0,16'h0,4'h0,0, 12, 4'h0,0,0,4'b1110,0,1); // n16 FFFF discarded
        // Reset has priority over a simultaneous load
        add(1,1,16'h9999,4'hF,0, 1, 4'h0,0,0,4'b1110,0,0); // n0
        add(0,0,16'h0,4'h0,1, 16, 4'h0,0,0,4'b1110,0,1); // n16 digit 0 never blanked
        add(0,0,16'h0,4'h0,1, 4,  4'h0,0,1,4'b1111,0,0); // n20 zero digit 1 blanked

        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].rst;
            load        = vecs[i].ld;
            data_in     = vecs[i].data;
            dots_in     = vecs[i].dots;
            lz_blank_en = vecs[i].lz;
            @(negedge clk);
            rst  = 1'b0;
            load = 1'b0;
            for (int k = 1; k < vecs[i].adv; k++) @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].hex, vecs[i].dot, vecs[i].blank, vecs[i].an, vecs[i].pend, vecs[i].fd});
        end

        // Hand sequence: overwrite within a frame, scanned cycle by cycle.
        // State is n20 (idx1). Loads land on edges 21 and 22; wraps at n32, n48.
        lz_blank_en = 1'b0;
        ones = 0; twos = 0; fds = 0;
        data_in = 16'h1111; load = 1'b1; @(negedge clk);
        data_in = 16'h2222; @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 30; c++) begin       // samples n23..n52
            @(negedge clk);
            if (hex_out == 4'h1) ones++;
            if (hex_out == 4'h2) twos++;
            if (frame_done) fds++;
        end
        n_tests++;
        if (ones != 0) begin n_fail++; $display("FAIL never_1111: saw hex 1 %0d times, required 0", ones); end
        n_tests++;
        if (twos != 21) begin n_fail++; $display("FAIL shows_2222: saw hex 2 %0d cycles, required 21", twos); end
        n_tests++;
        if (fds != 2) begin n_fail++; $display("FAIL frame_pulses: got %0d pulses, required 2", fds); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, refresh-tick period in clk cycles per digit slot (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load  input  1  one-cycle strobe; captures data_in/dots_in.
REQ-005 SHALL have port data_in  input  16  four hex nibbles; digit 0 = bits[3:0] (rightmost), digit 3 = bits[15:12].
REQ-006 SHALL have port dots_in  input  4  per-digit decimal point; bit k belongs to digit k.
REQ-007 SHALL have port lz_blank_en  input  1  leading-zero blanking enable, sampled live.
REQ-008 SHALL have port hex_out  output  4  nibble presented to the shared HEX seven-segment decoder.
REQ-009 SHALL have port dot_out  output  1  dot presented to the decoder for the current digit.
REQ-010 SHALL have port blank  output  1  high when the current digit slot is blanked.
REQ-011 SHALL have port an_n  output  4  active-low one-hot digit select; all ones when blanked.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.
REQ-013 SHALL have port pending  output  1  high while shadow data awaits transfer.

Function
REQ-014 Prescaler SHALL count 0..DIV-1 and wrap to 0; tick is asserted in the cycle where count == DIV-1.
REQ-015 Digit index idx (2 bits) SHALL increment on the clock edge at which tick is asserted and wrap 3 -> 0; otherwise hold.
REQ-016 A tick with idx == 3 is the wrap tick; frame_done SHALL be high for exactly the one cycle in which idx first reads 0 after it.
REQ-017 On load, data_in/dots_in SHALL be written to the shadow register and pending set to 1.
REQ-018 A load while pending == 1 SHALL overwrite the shadow register; last load wins, with no error indication.
REQ-019 On the wrap-tick edge with pending == 1, active SHALL take the shadow contents and pending SHALL clear to 0.
REQ-020 When load coincides with the wrap tick, active SHALL take data_in/dots_in directly, shadow SHALL take the same data, and pending SHALL be 0 afterwards.
REQ-021 Active data SHALL change only at frame boundaries; no mid-frame tearing.
REQ-022 hex_out SHALL equal active nibble [4*idx+3:4*idx] and dot_out SHALL equal active dot bit idx, decoded combinationally from registers with zero added latency.
REQ-023 an_n SHALL be the bitwise inverse of one-hot(idx) when blank == 0.
REQ-024 blank SHALL be 1 when all of the following hold:
- lz_blank_en == 1;
- idx > 0;
- every active nibble from idx through 3 is zero;
- the active dot bit idx is 0.
blank SHALL be 0 otherwise.
REQ-025 When blank == 1, an_n SHALL be 4'b1111; hex_out and dot_out SHALL still follow REQ-022.
REQ-026 Digit 0 SHALL never be blanked, so value 0 displays as "0".

Reset
REQ-027 While rst is high at a clock edge, the following SHALL be cleared: prescaler, idx, active, shadow, pending, frame_done.
REQ-028 After reset, the outputs SHALL be hex_out=0, dot_out=0, blank=0, an_n=4'b1110, frame_done=0, pending=0.
REQ-029 rst SHALL take priority over load and tick in the same cycle.
REQ-030 A load lost to reset mid-frame is discarded.
REQ-031 After rst deasserts, the first tick SHALL occur DIV cycles later.

Verification (DIV=4)
REQ-032 Reset, then hold idle 20 cycles -> an_n cycles 1110,1101,1011,0111 every 4 cycles; hex_out=0; pending=0; frame_done pulses every 16 cycles.
REQ-033 Load 16'h1234, dots=4'b0010 mid-frame -> pending=1 until wrap; next frame shows hex 4,3,2,1 on an_n 1110,1101,1011,0111, with dot_out=1 only on digit 1.
REQ-034 lz_blank_en=1, load 16'h0005, dots=0 -> after wrap: digit 0 hex 5 with an_n=1110; digits 1-3 blank=1 with an_n=1111. With dots=4'b0100, digit 2 is not blanked.
REQ-035 Load 16'hABCD on the wrap-tick cycle -> same frame starts with digit 0 = D; pending stays 0.
REQ-036 Load 16'h1111 then 16'h2222 in one frame -> next frame shows all 2s; 1111 is never displayed.
REQ-037 Load 16'hFFFF; assert rst on idx=2 mid-frame -> next edge gives an_n=1110, hex_out=0, pending=0; FFFF is never displayed.
